morse_symbol_classifier: RTL and testbench
==========================================

MORSE_SYMBOL_CLASSIFIER -- requirements
Module: morse_symbol_classifier

Interface
REQ-001 Parameter CNT_W, 16, width of the run-length counter in bits.
REQ-002 Parameter DEB_CYC, 4, number of consecutive equal synchronised samples required to accept a new line level.
REQ-003 Parameter DIT_MIN, 8, shortest accepted mark length in cycles; shorter marks are glitches.
REQ-004 Parameter DIT_MAX, 1000, longest mark length in cycles classified as DIT.
REQ-005 Parameter GAP_LEN, 3000, low-run length in cycles that marks a letter boundary.
REQ-006 Parameter SPACE_LEN, 7000, low-run length in cycles that marks a word boundary.
REQ-007 clk  input  1  system clock; all state changes on the rising edge.
REQ-008 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-009 signal  input  1  raw asynchronous keyed line; high = mark (tone on).
REQ-010 sym_valid  output  1  single-cycle strobe; sym is valid in that cycle.
REQ-011 sym  output  3  symbol code: WAIT=0, DIT=1, DAH=2, GAP=3, SPACE=4.
REQ-012 sym_err  output  1  single-cycle strobe for a discarded mark shorter than DIT_MIN.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 signal SHALL pass through a 2-flop synchroniser and then a debouncer; the debounced level changes only after DEB_CYC consecutive equal synchronised samples.
REQ-015 The run counter SHALL load 1 in the cycle the debounced level changes, increment by 1 each cycle while the level holds, and saturate at 2^CNT_W-1 without wrapping.
REQ-016 The FSM SHALL have states IDLE (line low, nothing pending), MARK (line high) and LOW (line low after a mark).
REQ-017 IDLE -> MARK on a debounced rising edge; no output is produced.
REQ-018 MARK -> LOW on a debounced falling edge; the mark length is the counter value immediately before the edge.
REQ-019 On MARK -> LOW, a mark length below DIT_MIN SHALL pulse sym_err and emit no symbol; DIT_MIN..DIT_MAX SHALL emit DIT; above DIT_MAX SHALL emit DAH, including a saturated count.
REQ-020 Mark classification SHALL appear on sym_valid/sym exactly one cycle after the debounced falling edge.
REQ-021 In LOW, GAP SHALL be emitted once, one cycle after the counter reaches GAP_LEN.
REQ-022 In LOW, SPACE SHALL be emitted once, one cycle after the counter reaches SPACE_LEN, followed by LOW -> IDLE.
REQ-023 LOW -> MARK on a debounced rising edge before SPACE_LEN, with no emission; this covers both intra-letter gaps and post-GAP new letters.
REQ-024 Only one sym_valid strobe SHALL occur per cycle.
REQ-025 A glitch mark SHALL still enter LOW, so a GAP/SPACE can follow a discarded mark.
REQ-026 When sym_valid=0, sym SHALL read WAIT.
REQ-027 The module SHALL require DIT_MIN<=DIT_MAX<GAP_LEN<SPACE_LEN<2^CNT_W-1 and DEB_CYC>=1, checked at elaboration.

Reset
REQ-028 On rst_n low, the following SHALL clear asynchronously: FSM=IDLE, counter=0, synchroniser/debouncer=0 (line low), sym=WAIT, sym_valid=0, sym_err=0, busy=0.
REQ-029 A reset asserted mid-mark or mid-gap SHALL discard the partial run with no emission; after release, a line already high enters MARK only after sync+DEB_CYC cycles.

Structure
REQ-030 Symbol codes WAIT/DIT/DAH/GAP/SPACE and the FSM state encoding SHALL be defined in the shared package morse_pkg.
REQ-031 The synchroniser and debouncer SHALL be a sub-module morse_line_conditioner (ports clk, rst_n, din, dout).

Verification (CNT_W=8, DEB_CYC=2, DIT_MIN=4, DIT_MAX=20, GAP_LEN=40, SPACE_LEN=100)
REQ-032 Mark of 10 cycles then a low run of 150 cycles -> DIT, then GAP 40 low-cycles after the fall, then SPACE at 100, then busy=0.
REQ-033 Mark of 30 cycles, low 10, mark 10, low 150 -> DAH, DIT, GAP, SPACE, with no GAP between the two marks.
REQ-034 Mark of 2 cycles (above the debounce but below DIT_MIN) -> sym_err strobe, no DIT; a GAP still follows after 40 low cycles.
REQ-035 Mark held 300 cycles (counter saturates at 255) -> DAH, with no wrap-induced DIT.
REQ-036 1-cycle raw pulses on signal -> no busy, no strobes (debounce rejects them).
REQ-037 rst_n pulsed low at cycle 15 of a 30-cycle mark -> all outputs cleared immediately, with no symbol emitted for the truncated mark.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared symbol codes and FSM state encoding for the Morse classifier.
// Latency: none (constants only).
// Backpressure: not applicable.
package morse_pkg;

    typedef logic [2:0] sym_t;

    localparam sym_t SYM_WAIT  = 3'd0;
    localparam sym_t SYM_DIT   = 3'd1;
    localparam sym_t SYM_DAH   = 3'd2;
    localparam sym_t SYM_GAP   = 3'd3;
    localparam sym_t SYM_SPACE = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MARK = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/morse_line_conditioner.sv
// Two-flop synchroniser followed by a debouncer for the raw keyed line.
// Latency: 2 sync cycles plus DEB_CYC equal samples before dout changes.
// Backpressure: none; free-running, dout follows din once din is stable.
module morse_line_conditioner #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    logic          dout_q;
    logic          dout_d;

    // Count consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    always_comb begin
        deb_cnt_d = '0;
        dout_d    = dout_q;
        if (sync2_q != dout_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                dout_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= '0;
            dout_q    <= 1'b0;
        end else begin
            sync1_q   <= din;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
            dout_q    <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/morse_symbol_classifier.sv
// Classifies debounced mark/space run lengths into DIT/DAH/GAP/SPACE symbols.
// Latency: symbol strobes one cycle after the deciding debounced edge or count.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
module morse_symbol_classifier
    import morse_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DEB_CYC   = 4,
    parameter int DIT_MIN   = 8,
    parameter int DIT_MAX   = 1000,
    parameter int GAP_LEN   = 3000,
    parameter int SPACE_LEN = 7000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal,
    output logic       sym_valid,
    output logic [2:0] sym,
    output logic       sym_err,
    output logic       busy
);

    if (!(DIT_MIN <= DIT_MAX && DIT_MAX < GAP_LEN && GAP_LEN < SPACE_LEN &&
          longint'(SPACE_LEN) < (longint'(1) << CNT_W) - 1 && DEB_CYC >= 1)) begin : g_param_chk
        $error("morse_symbol_classifier: inconsistent timing parameters");
    end

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] DIT_MIN_C = CNT_W'(DIT_MIN);
    localparam logic [CNT_W-1:0] DIT_MAX_C = CNT_W'(DIT_MAX);
    localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP_LEN);
    localparam logic [CNT_W-1:0] SPACE_C   = CNT_W'(SPACE_LEN);

    logic             line_lvl;
    logic             lvl_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    sym_t             sym_q;
    sym_t             sym_d;
    logic             sym_valid_q;
    logic             sym_valid_d;
    logic             sym_err_q;
    logic             sym_err_d;

    morse_line_conditioner #(
        .DEB_CYC (DEB_CYC)
    ) u_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (signal),
        .dout  (line_lvl)
    );

    assign rise = line_lvl & ~lvl_q;
    assign fall = ~line_lvl & lvl_q;

    // cnt_q holds the length of the run that just ended during an edge cycle.
    assign cnt_d = (rise || fall)      ? CNT_ONE :
                   (cnt_q == CNT_MAX) ? cnt_q   : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sym_d       = SYM_WAIT;
        sym_valid_d = 1'b0;
        sym_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_MARK;
            end
            ST_MARK: begin
                if (fall) begin
                    state_d = ST_LOW;
                    if (cnt_q < DIT_MIN_C) begin
                        sym_err_d = 1'b1;
                    end else begin
                        sym_valid_d = 1'b1;
                        sym_d       = (cnt_q <= DIT_MAX_C) ? SYM_DIT : SYM_DAH;
                    end
                end
            end
            ST_LOW: begin
                // A new mark always wins over a boundary landing on the same cycle.
                if (rise) begin
                    state_d = ST_MARK;
                end else if (cnt_q == GAP_C) begin
                    sym_valid_d = 1'b1;
                    sym_d       = SYM_GAP;
                end else if (cnt_q == SPACE_C) begin
                    sym_valid_d = 1'b1;
                    sym_d       = SYM_SPACE;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            sym_q       <= SYM_WAIT;
            sym_valid_q <= 1'b0;
            sym_err_q   <= 1'b0;
        end else begin
            lvl_q       <= line_lvl;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            sym_err_q   <= sym_err_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign sym_err   = sym_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Bench for morse_symbol_classifier: run-length reference model checked every
// cycle, plus directed scenarios pinned with literal expectations.
module tb_morse_symbol_classifier;

    localparam int CNT_W = 8;
    localparam int DEB   = 2;
    localparam int DMIN  = 4;
    localparam int DMAX  = 20;
    localparam int GAP   = 40;
    localparam int SPACE = 100;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       signal = 1'b0;
    logic       sym_valid;
    logic [2:0] sym;
    logic       sym_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    morse_symbol_classifier #(
        .CNT_W     (CNT_W),
        .DEB_CYC   (DEB),
        .DIT_MIN   (DMIN),
        .DIT_MAX   (DMAX),
        .GAP_LEN   (GAP),
        .SPACE_LEN (SPACE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal    (signal),
        .sym_valid (sym_valid),
        .sym       (sym),
        .sym_err   (sym_err),
        .busy      (busy)
    );

    // Reference model: edge index since reset, sampled line history,
    // accepted level, and scheduled emissions (edge index, -1 = none).
    bit       raw_h[$];
    bit       samp_h[$];
    int       t;
    bit       deb_m;
    int       rise_at, cls_at, gap_at, space_at, busy_on_at;
    bit       cls_err_m;
    logic [2:0] cls_sym_m;
    logic     e_vld, e_err, e_busy;
    logic [2:0] e_sym;

    int log_cyc[$];
    int log_sym[$];
    int err_log;
    bit busy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        raw_h.delete();
        samp_h.delete();
        t = 0; deb_m = 1'b0;
        rise_at = 0; cls_at = -1; gap_at = -1; space_at = -1; busy_on_at = -1;
        cls_err_m = 1'b0; cls_sym_m = 3'd0;
        e_vld = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_sym = 3'd0;
    endtask

    task automatic model_step();
        bit s;
        bit flip;
        int len;
        raw_h.push_back(signal);
        s = (t >= 2) ? raw_h[t-2] : 1'b0;
        samp_h.push_back(s);
        e_vld = 1'b0; e_err = 1'b0; e_sym = 3'd0;
        if (t == cls_at) begin
            if (cls_err_m) e_err = 1'b1;
            else begin e_vld = 1'b1; e_sym = cls_sym_m; end
        end
        if (t == gap_at)   begin e_vld = 1'b1; e_sym = 3'd3; end
        if (t == space_at) begin e_vld = 1'b1; e_sym = 3'd4; e_busy = 1'b0; end
        if (t == busy_on_at) e_busy = 1'b1;
        // Accepted level flips when the last DEB samples all disagree with it.
        flip = (t + 1 >= DEB);
        if (flip) begin
            for (int k = 0; k < DEB; k++) begin
                if (samp_h[t-k] == deb_m) flip = 1'b0;
            end
        end
        if (flip) begin
            deb_m = !deb_m;
            if (deb_m) begin
                rise_at = t; busy_on_at = t + 1; gap_at = -1; space_at = -1;
            end else begin
                len       = t - rise_at;
                cls_at    = t + 1;
                cls_err_m = (len < DMIN);
                cls_sym_m = (len <= DMAX) ? 3'd1 : 3'd2;
                gap_at    = t + GAP + 1;
                space_at  = t + SPACE + 1;
            end
        end
        t++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            cyc++;
            model_step();
        end
        #1;
        check("sym_valid", sym_valid, e_vld);
        check("sym", sym, e_sym);
        check("sym_err", sym_err, e_err);
        check("busy", busy, e_busy);
        if (rst_n && sym_valid) begin log_cyc.push_back(cyc); log_sym.push_back(int'(sym)); end
        if (rst_n && sym_err) err_log++;
        if (busy) busy_seen = 1'b1;
    end

    function automatic int sym_at(input int i);
        return (i < log_sym.size()) ? log_sym[i] : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1;
    endfunction

    task automatic clear_log();
        log_cyc.delete();
        log_sym.delete();
        err_log   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic drive(input bit lvl, input int n, output int first);
        first = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first = cyc + 1;
            signal = lvl;
        end
    endtask

    initial begin
        int x;
        int ml, ll, kind;
        model_reset();
        clear_log();
        repeat (3) @(negedge clk);
        check("reset_sym_valid", sym_valid, 0);
        check("reset_sym", sym, 0);
        check("reset_busy", busy, 0);
        #2 rst_n = 1'b1;
        drive(0, 5, x);

        // DIT, then GAP 40 edges and SPACE 100 edges after the DIT strobe.
        clear_log();
        drive(1, 10, x);
        drive(0, 150, x);
        check("s1_count", log_sym.size(), 3);
        check("s1_dit", sym_at(0), 1);
        check("s1_dit_latency", cyc_at(0) - x, DEB + 2);
        check("s1_gap", sym_at(1), 3);
        check("s1_gap_offset", cyc_at(1) - cyc_at(0), 40);
        check("s1_space", sym_at(2), 4);
        check("s1_space_offset", cyc_at(2) - cyc_at(0), 100);
        check("s1_busy_end", busy, 0);

        // DAH, DIT with no GAP between the marks.
        clear_log();
        drive(1, 30, x); drive(0, 10, x); drive(1, 10, x); drive(0, 150, x);
        check("s2_count", log_sym.size(), 4);
        check("s2_dah", sym_at(0), 2);
        check("s2_dit", sym_at(1), 1);
        check("s2_gap", sym_at(2), 3);
        check("s2_space", sym_at(3), 4);

        // Glitch mark: error strobe only, boundaries still follow.
        clear_log();
        drive(1, 2, x); drive(0, 150, x);
        check("s3_err_count", err_log, 1);
        check("s3_count", log_sym.size(), 2);
        check("s3_gap", sym_at(0), 3);

        // Long marks: counter saturates rather than wrapping into DIT range.
        clear_log();
        drive(1, 300, x); drive(0, 150, x);
        check("s4_count", log_sym.size(), 3);
        check("s4_dah", sym_at(0), 2);
        clear_log();
        drive(1, 262, x); drive(0, 150, x);
        check("s4b_dah", sym_at(0), 2);

        // Single-cycle pulses never get past the debouncer.
        clear_log();
        for (int i = 0; i < 20; i++) begin drive(1, 1, x); drive(0, 3, x); end
        drive(0, 10, x);
        check("s5_strobes", log_sym.size(), 0);
        check("s5_errs", err_log, 0);
        check("s5_busy_seen", busy_seen, 0);

        // Reset mid-mark: outputs clear at once, truncated mark never reported.
        clear_log();
        drive(1, 15, x);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_busy", busy, 0);
        check("s6_rst_valid", sym_valid, 0);
        check("s6_rst_err", sym_err, 0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1, 13, x); drive(0, 150, x);
        check("s6_count", log_sym.size(), 3);
        check("s6_first_dit", sym_at(0), 1);

        // Randomised runs, with occasional resets, checked against the model.
        for (int seg = 0; seg < 160; seg++) begin
            kind = $urandom_range(0, 9);
            ml = (kind < 2) ? $urandom_range(1, 3) :
                 (kind < 7) ? $urandom_range(4, 30) : $urandom_range(31, 300);
            kind = $urandom_range(0, 9);
            ll = (kind < 3) ? $urandom_range(1, 6) :
                 (kind < 7) ? $urandom_range(7, 60) : $urandom_range(90, 130);
            drive(1, ml, x);
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk); #2 rst_n = 1'b0;
                @(negedge clk); #2 rst_n = 1'b1;
            end
            drive(0, ll, x);
        end
        drive(0, 150, x);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
